// File: rtl/gaussian_launch_pkg.sv
// +-----------------------------------------------------------------------------+
// | gaussian_launch_pkg : shared types and helpers for the gaussian launcher    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package gaussian_launch_pkg;

    localparam int ADDR_W = 64;
    localparam int TS_W   = 32;

    typedef logic [ADDR_W-1:0] job_t;

    typedef struct packed {
        job_t            addr;
        logic [TS_W-1:0] ts;
    } inflight_t;

    // Pointer width that stays at least one bit for a single-entry FIFO.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gaussian_sync_fifo.sv
// +-----------------------------------------------------------------------------+
// | gaussian_sync_fifo : first-word-fall-through synchronous FIFO               |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module gaussian_sync_fifo
    import gaussian_launch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd_ptr];

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/gaussian_launcher.sv
// +-----------------------------------------------------------------------------+
// | gaussian_launcher : queues jobs, issues gaussian calls, returns in-order     |
// |                     responses with measured call-to-return latency           |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module gaussian_launcher
    import gaussian_launch_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 2,
    parameter int CNT_W        = 32
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [63:0]       job_addr,
    output logic              start,
    input  logic              busy,
    output logic [63:0]       A_r,
    input  logic              done,
    output logic              stall,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_addr,
    output logic [CNT_W-1:0]  resp_latency,
    output logic [CNT_W-1:0]  jobs_completed,
    output logic              idle,
    output logic              err
);

    localparam int INF_W = ADDR_W + CNT_W;

    logic             r_alive;
    logic [CNT_W-1:0] r_ts;
    logic [CNT_W-1:0] r_latency;
    logic [CNT_W-1:0] r_completed;
    job_t             r_resp_addr;
    logic             r_resp_valid;
    logic             r_err;

    job_t             w_job_head;
    logic             w_job_full;
    logic             w_job_empty;
    logic [INF_W-1:0] w_inf_head;
    logic             w_inf_full;
    logic             w_inf_empty;
    logic             w_push_job;
    logic             w_call;
    logic             w_ret;

    assign job_ready  = r_alive && !w_job_full;
    assign w_push_job = job_valid && job_ready;

    // Issue depends only on registered FIFO state, so start/A_r hold under busy.
    assign start  = !w_job_empty && !w_inf_full;
    assign A_r    = start ? w_job_head : '0;
    assign w_call = start && !busy;

    assign stall = r_resp_valid && !resp_ready;
    assign w_ret = done && !stall && !w_inf_empty;

    assign resp_valid     = r_resp_valid;
    assign resp_addr      = r_resp_addr;
    assign resp_latency   = r_latency;
    assign jobs_completed = r_completed;
    assign err            = r_err;
    assign idle           = w_job_empty && w_inf_empty && !r_resp_valid;

    gaussian_sync_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_job_fifo (
        .clk   (clock),
        .rst_n (resetn),
        .push  (w_push_job),
        .din   (job_addr),
        .pop   (w_call),
        .dout  (w_job_head),
        .full  (w_job_full),
        .empty (w_job_empty)
    );

    gaussian_sync_fifo #(
        .WIDTH (INF_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_inflight_fifo (
        .clk   (clock),
        .rst_n (resetn),
        .push  (w_call),
        .din   ({w_job_head, r_ts}),
        .pop   (w_ret),
        .dout  (w_inf_head),
        .full  (w_inf_full),
        .empty (w_inf_empty)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_alive      <= 1'b0;
            r_ts         <= '0;
            r_latency    <= '0;
            r_completed  <= '0;
            r_resp_addr  <= '0;
            r_resp_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            r_ts    <= r_ts + 1'b1;
            if (done && w_inf_empty) begin
                r_err <= 1'b1;
            end
            if (w_ret) begin
                r_resp_addr  <= w_inf_head[INF_W-1:CNT_W];
                r_latency    <= r_ts - w_inf_head[CNT_W-1:0];
                r_resp_valid <= 1'b1;
                r_completed  <= r_completed + 1'b1;
            end else if (resp_ready) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
